// File: rtl/readback_scan_sequencer.sv
// Arbitrates the readback mux address between a PS host and a table-driven scanner
// that captures settled A/B word pairs onto a valid/ready stream. Optional: RB_SEQ_TIMESTAMP_EN.
module readback_scan_sequencer #(
    parameter int          N_SLOTS       = 8,
    parameter int          SETTLE_CYCLES = 2,
    parameter logic [31:0] IDLE_ADDR     = 32'd0,
    localparam int         SW            = $clog2(N_SLOTS)
) (
    input  logic          aclk,
    input  logic          aresetn,
    input  logic          host_req,
    input  logic [31:0]   host_addr,
    output logic          host_grant,
    input  logic          slot_we,
    input  logic [SW-1:0] slot_idx,
    input  logic [31:0]   slot_addr,
    input  logic [4:0]    n_active,
    input  logic          start,
    input  logic          continuous,
    output logic [31:0]   config_addr,
    input  logic [31:0]   rb_dataA,
    input  logic [31:0]   rb_dataB,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [31:0]   m_dataA,
    output logic [31:0]   m_dataB,
`ifdef RB_SEQ_TIMESTAMP_EN
    output logic [31:0]   m_tstamp,
`endif
    output logic [SW-1:0] m_slot,
    output logic          m_last,
    output logic          busy,
    output logic [15:0]   sweep_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SET,
        S_SETTLE,
        S_CAPTURE,
        S_PUSH,
        S_HOST
    } state_e;

    localparam logic [4:0] N_SLOTS_5   = 5'(N_SLOTS);
    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES);

    state_e        state_q, state_d;
    logic [SW-1:0] slot_q, slot_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [4:0]    eff_q, eff_d;
    logic          susp_q, susp_d;
    logic [31:0]   config_addr_q, config_addr_d;
    logic          host_grant_q, host_grant_d;
    logic          m_valid_q, m_valid_d;
    logic [31:0]   m_dataA_q, m_dataA_d;
    logic [31:0]   m_dataB_q, m_dataB_d;
    logic [SW-1:0] m_slot_q, m_slot_d;
    logic          m_last_q, m_last_d;
    logic          busy_q, busy_d;
    logic [15:0]   sweep_cnt_q, sweep_cnt_d;
    logic [31:0]   table_q [N_SLOTS];
    logic [31:0]   table_d [N_SLOTS];
`ifdef RB_SEQ_TIMESTAMP_EN
    logic [31:0]   tstamp_cnt_q, tstamp_cnt_d;
    logic [31:0]   m_tstamp_q, m_tstamp_d;
`endif

    logic [4:0] eff_in;
    logic       is_last;
    logic       resume;

    assign eff_in  = (n_active > N_SLOTS_5) ? N_SLOTS_5 : n_active;
    assign is_last = ((5'(slot_q) + 5'd1) == eff_q);

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        state_d       = state_q;
        slot_d        = slot_q;
        cnt_d         = cnt_q;
        eff_d         = eff_q;
        susp_d        = susp_q;
        config_addr_d = config_addr_q;
        host_grant_d  = host_grant_q;
        m_valid_d     = m_valid_q;
        m_dataA_d     = m_dataA_q;
        m_dataB_d     = m_dataB_q;
        m_slot_d      = m_slot_q;
        m_last_d      = m_last_q;
        sweep_cnt_d   = sweep_cnt_q;
        table_d       = table_q;
        resume        = 1'b0;
`ifdef RB_SEQ_TIMESTAMP_EN
        tstamp_cnt_d  = tstamp_cnt_q + 32'd1;
        m_tstamp_d    = m_tstamp_q;
`endif

        if (slot_we) begin
            table_d[slot_idx] = slot_addr;
        end

        case (state_q)
            S_IDLE: begin
                if (host_req) begin
                    state_d       = S_HOST;
                    host_grant_d  = 1'b1;
                    config_addr_d = host_addr;
                    susp_d        = 1'b0;
                end else if (start && (eff_in != 5'd0)) begin
                    eff_d   = eff_in;
                    slot_d  = '0;
                    state_d = S_SET;
                end
            end
            S_SET, S_SETTLE: begin
                if (host_req) begin
                    // Abort the slot; slot_q is kept so the whole slot is redone later.
                    state_d       = S_HOST;
                    host_grant_d  = 1'b1;
                    config_addr_d = host_addr;
                    susp_d        = 1'b1;
                end else if (state_q == S_SET) begin
                    config_addr_d = table_q[slot_q];
                    cnt_d         = SETTLE_LOAD;
                    state_d       = S_SETTLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q <= 4'd1) begin
                        state_d = S_CAPTURE;
                    end
                end
            end
            S_CAPTURE: begin
                m_valid_d = 1'b1;
                m_dataA_d = rb_dataA;
                m_dataB_d = rb_dataB;
                m_slot_d  = slot_q;
                m_last_d  = is_last;
`ifdef RB_SEQ_TIMESTAMP_EN
                m_tstamp_d = tstamp_cnt_q;
`endif
                state_d   = S_PUSH;
            end
            S_PUSH: begin
                if (m_ready) begin
                    m_valid_d = 1'b0;
                    if (!m_last_q) begin
                        slot_d = slot_q + 1'b1;
                        resume = 1'b1;
                    end else begin
                        sweep_cnt_d = sweep_cnt_q + 16'd1;
                        if (continuous) begin
                            slot_d = '0;
                            eff_d  = eff_in;
                            resume = (eff_in != 5'd0);
                        end
                    end
                    if (host_req) begin
                        state_d       = S_HOST;
                        host_grant_d  = 1'b1;
                        config_addr_d = host_addr;
                        susp_d        = resume;
                    end else begin
                        state_d = resume ? S_SET : S_IDLE;
                    end
                end
            end
            S_HOST: begin
                config_addr_d = host_addr;
                if (!host_req) begin
                    host_grant_d = 1'b0;
                    state_d      = susp_q ? S_SET : S_IDLE;
                    susp_d       = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (state_d == S_IDLE) begin
            config_addr_d = IDLE_ADDR;
        end

        busy_d = !((state_d == S_IDLE) || ((state_d == S_HOST) && !susp_d));
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q       <= S_IDLE;
            slot_q        <= '0;
            cnt_q         <= '0;
            eff_q         <= '0;
            susp_q        <= 1'b0;
            config_addr_q <= IDLE_ADDR;
            host_grant_q  <= 1'b0;
            m_valid_q     <= 1'b0;
            m_dataA_q     <= '0;
            m_dataB_q     <= '0;
            m_slot_q      <= '0;
            m_last_q      <= 1'b0;
            busy_q        <= 1'b0;
            sweep_cnt_q   <= '0;
            // NOTE: the table is small and must read back IDLE_ADDR after reset, so it is
            // built from resettable flops rather than an inferred RAM.
            for (int i = 0; i < N_SLOTS; i++) begin
                table_q[i] <= IDLE_ADDR;
            end
`ifdef RB_SEQ_TIMESTAMP_EN
            tstamp_cnt_q  <= '0;
            m_tstamp_q    <= '0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge _d values.
            state_q       <= state_d;
            slot_q        <= slot_d;
            cnt_q         <= cnt_d;
            eff_q         <= eff_d;
            susp_q        <= susp_d;
            config_addr_q <= config_addr_d;
            host_grant_q  <= host_grant_d;
            m_valid_q     <= m_valid_d;
            m_dataA_q     <= m_dataA_d;
            m_dataB_q     <= m_dataB_d;
            m_slot_q      <= m_slot_d;
            m_last_q      <= m_last_d;
            busy_q        <= busy_d;
            sweep_cnt_q   <= sweep_cnt_d;
            table_q       <= table_d;
`ifdef RB_SEQ_TIMESTAMP_EN
            tstamp_cnt_q  <= tstamp_cnt_d;
            m_tstamp_q    <= m_tstamp_d;
`endif
        end
    end

    assign config_addr = config_addr_q;
    assign host_grant  = host_grant_q;
    assign m_valid     = m_valid_q;
    assign m_dataA     = m_dataA_q;
    assign m_dataB     = m_dataB_q;
    assign m_slot      = m_slot_q;
    assign m_last      = m_last_q;
    assign busy        = busy_q;
    assign sweep_cnt   = sweep_cnt_q;
`ifdef RB_SEQ_TIMESTAMP_EN
    assign m_tstamp    = m_tstamp_q;
`endif

endmodule

// File: tb/tb_readback_scan_sequencer.sv
// Directed bench for readback_scan_sequencer: a simple mux model answers config_addr
// with offset A/B words, and vectors carry hand-computed expected pairs.
module tb_readback_scan_sequencer;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic        host_req;
    logic [31:0] host_addr;
    logic        host_grant;
    logic        slot_we;
    logic [2:0]  slot_idx;
    logic [31:0] slot_addr;
    logic [4:0]  n_active;
    logic        start;
    logic        continuous;
    logic [31:0] config_addr;
    logic [31:0] rb_dataA;
    logic [31:0] rb_dataB;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] m_dataA;
    logic [31:0] m_dataB;
    logic [2:0]  m_slot;
    logic        m_last;
    logic        busy;
    logic [15:0] sweep_cnt;
`ifdef RB_SEQ_TIMESTAMP_EN
    logic [31:0] m_tstamp;
`endif

    int total = 0;
    int bad   = 0;
    int hs_cnt [8];

    always #5 aclk = ~aclk;

    // Mux model: A and B words are the address plus fixed offsets.
    assign rb_dataA = config_addr + 32'h1000_0000;
    assign rb_dataB = config_addr + 32'h2000_0000;

    readback_scan_sequencer dut (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .host_req    (host_req),
        .host_addr   (host_addr),
        .host_grant  (host_grant),
        .slot_we     (slot_we),
        .slot_idx    (slot_idx),
        .slot_addr   (slot_addr),
        .n_active    (n_active),
        .start       (start),
        .continuous  (continuous),
        .config_addr (config_addr),
        .rb_dataA    (rb_dataA),
        .rb_dataB    (rb_dataB),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_dataA     (m_dataA),
        .m_dataB     (m_dataB),
`ifdef RB_SEQ_TIMESTAMP_EN
        .m_tstamp    (m_tstamp),
`endif
        .m_slot      (m_slot),
        .m_last      (m_last),
        .busy        (busy),
        .sweep_cnt   (sweep_cnt)
    );

    initial begin
        for (int i = 0; i < 8; i++) hs_cnt[i] = 0;
    end

    always @(posedge aclk) begin
        if (aresetn && m_valid && m_ready) hs_cnt[m_slot] <= hs_cnt[m_slot] + 1;
    end

    typedef struct {
        logic [2:0]  slot;
        logic [31:0] addr;
        logic [31:0] exp_a;
        logic [31:0] exp_b;
        logic        last;
        int          lat;
    } vec_t;

    vec_t        sweep_v [3];
    logic [31:0] exp_addr [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_valid(input string name, output int lat);
        bit found = 0;
        lat = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge aclk);
            lat++;
            if (m_valid === 1'b1) found = 1;
        end
        if (!found) begin
            total++;
            bad++;
            $display("FAIL %s: m_valid never rose within %0d cycles", name, lat);
        end
    endtask

    task automatic write_slot(input logic [2:0] idx, input logic [31:0] addr);
        slot_we   = 1'b1;
        slot_idx  = idx;
        slot_addr = addr;
        @(negedge aclk);
        slot_we   = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge aclk);
        start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int slot1_before;

        sweep_v[0] = '{3'd0, 32'd100001, 32'h1001_86A1, 32'h2001_86A1, 1'b0, 4};
        sweep_v[1] = '{3'd1, 32'd100002, 32'h1001_86A2, 32'h2001_86A2, 1'b0, 5};
        sweep_v[2] = '{3'd2, 32'd100006, 32'h1001_86A6, 32'h2001_86A6, 1'b1, 5};
        exp_addr   = '{32'd100001, 32'd100002, 32'd100006, 0, 0, 0, 0, 0};

        aresetn = 1'b0; host_req = 0; host_addr = 0; slot_we = 0; slot_idx = 0;
        slot_addr = 0; n_active = 0; start = 0; continuous = 0; m_ready = 1;
        repeat (3) @(negedge aclk);

        // Reset state
        check("rst config_addr", config_addr, 32'd0);
        check("rst m_valid", m_valid, 0);
        check("rst m_dataA", m_dataA, 0);
        check("rst m_dataB", m_dataB, 0);
        check("rst m_slot", m_slot, 0);
        check("rst m_last", m_last, 0);
        check("rst host_grant", host_grant, 0);
        check("rst busy", busy, 0);
        check("rst sweep_cnt", sweep_cnt, 0);
        aresetn = 1'b1;
        @(negedge aclk);

        for (int i = 0; i < 3; i++) write_slot(sweep_v[i].slot, sweep_v[i].addr);

        // Single sweep
        n_active = 3;
        pulse_start();
        check("sweep busy", busy, 1);
        for (int i = 0; i < 3; i++) begin
            wait_valid("sweep valid", lat);
            check("sweep latency", lat, sweep_v[i].lat);
            check("sweep config_addr", config_addr, sweep_v[i].addr);
            check("sweep m_slot", m_slot, sweep_v[i].slot);
            check("sweep m_dataA", m_dataA, sweep_v[i].exp_a);
            check("sweep m_dataB", m_dataB, sweep_v[i].exp_b);
            check("sweep m_last", m_last, sweep_v[i].last);
        end
        @(negedge aclk);
        check("sweep end busy", busy, 0);
        check("sweep end sweep_cnt", sweep_cnt, 1);
        check("sweep end config_addr", config_addr, 0);
        check("sweep end m_valid", m_valid, 0);

        // Backpressure
        n_active = 2;
        m_ready  = 0;
        pulse_start();
        wait_valid("bp valid", lat);
        check("bp latency", lat, 4);
        for (int i = 0; i < 20; i++) begin
            @(negedge aclk);
            check("bp hold m_valid", m_valid, 1);
            check("bp hold m_dataA", m_dataA, 32'h1001_86A1);
            check("bp hold m_slot", m_slot, 0);
            check("bp hold config_addr", config_addr, 32'd100001);
        end
        m_ready = 1;
        @(negedge aclk);
        check("bp release m_valid", m_valid, 0);
        wait_valid("bp slot1 valid", lat);
        check("bp slot1 latency", lat, 4);
        check("bp slot1 m_slot", m_slot, 1);
        check("bp slot1 m_dataB", m_dataB, 32'h2001_86A2);
        check("bp slot1 m_last", m_last, 1);
        @(negedge aclk);
        check("bp sweep_cnt", sweep_cnt, 2);
        check("bp busy", busy, 0);

        // Host preemption during slot 1 SETTLE
        n_active = 3;
        slot1_before = hs_cnt[1];
        pulse_start();
        wait_valid("pre slot0 valid", lat);
        check("pre slot0 m_slot", m_slot, 0);
        @(negedge aclk);
        @(negedge aclk);
        host_req  = 1;
        host_addr = 32'd199997;
        @(negedge aclk);
        check("pre host config_addr", config_addr, 32'd199997);
        check("pre host_grant", host_grant, 1);
        check("pre host busy", busy, 1);
        repeat (3) begin
            @(negedge aclk);
            check("pre hold config_addr", config_addr, 32'd199997);
            check("pre hold m_valid", m_valid, 0);
        end
        host_req = 0;
        @(negedge aclk);
        check("pre release host_grant", host_grant, 0);
        check("pre release busy", busy, 1);
        wait_valid("pre slot1 valid", lat);
        check("pre slot1 latency", lat, 4);
        check("pre slot1 m_slot", m_slot, 1);
        check("pre slot1 config_addr", config_addr, 32'd100002);
        check("pre slot1 m_dataA", m_dataA, 32'h1001_86A2);
        @(negedge aclk);
        wait_valid("pre slot2 valid", lat);
        check("pre slot2 m_slot", m_slot, 2);
        check("pre slot2 m_last", m_last, 1);
        @(negedge aclk);
        check("pre slot1 pair count", hs_cnt[1] - slot1_before, 1);
        check("pre sweep_cnt", sweep_cnt, 3);
        check("pre busy", busy, 0);

        // Continuous sweeps with clamped count; unwritten slots read IDLE_ADDR
        n_active   = 20;
        continuous = 1;
        pulse_start();
        for (int i = 0; i < 16; i++) begin
            wait_valid("cont valid", lat);
            check("cont latency", lat, (i == 0) ? 4 : 5);
            check("cont m_slot", m_slot, i % 8);
            check("cont config_addr", config_addr, exp_addr[i % 8]);
            check("cont m_dataA", m_dataA, exp_addr[i % 8] + 32'h1000_0000);
            check("cont m_last", m_last, (i % 8) == 7);
            if (i == 11) continuous = 0;
        end
        @(negedge aclk);
        check("cont end busy", busy, 0);
        check("cont end sweep_cnt", sweep_cnt, 5);
        check("cont end config_addr", config_addr, 0);

        // start with n_active=0 is ignored
        n_active = 0;
        pulse_start();
        check("zero busy", busy, 0);
        repeat (6) @(negedge aclk);
        check("zero m_valid", m_valid, 0);
        check("zero sweep_cnt", sweep_cnt, 5);

        // Asynchronous reset while a pair waits in PUSH
        n_active = 1;
        m_ready  = 0;
        pulse_start();
        wait_valid("rst valid", lat);
        check("rst pre m_valid", m_valid, 1);
        #2 aresetn = 1'b0;
        #1;
        check("async m_valid", m_valid, 0);
        check("async m_dataA", m_dataA, 0);
        check("async m_last", m_last, 0);
        check("async busy", busy, 0);
        check("async sweep_cnt", sweep_cnt, 0);
        check("async config_addr", config_addr, 0);
        @(negedge aclk);
        aresetn = 1'b1;
        m_ready = 1;
        @(negedge aclk);
        pulse_start();
        wait_valid("post rst valid", lat);
        check("post rst latency", lat, 4);
        check("post rst config_addr", config_addr, 0);
        check("post rst m_dataA", m_dataA, 32'h1000_0000);
        check("post rst m_dataB", m_dataB, 32'h2000_0000);
        check("post rst m_last", m_last, 1);
        @(negedge aclk);
        check("post rst sweep_cnt", sweep_cnt, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
